// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI flash target model. Oversamples the SPI pins on the system
//            clock, decodes a read opcode plus 24-bit address and streams
//            bytes MSB-first on MISO from a byte-wide synchronous memory port.
//            SPI modes 0 and 3 are supported (MOSI sampled on SCK rise, MISO
//            updated on SCK fall).
// Ports    : clock, reset (sync, active-low)
//            spi_cs_n, spi_sck, spi_mosi in; spi_miso out
//            mem_rd / mem_addr out, mem_rdata in (valid 1 clock after mem_rd)
//            busy (state not IDLE), cmd_err (1-cycle unsupported-opcode pulse)
// Options  : define SPI_FLASH_RESPONDER_FASTREAD_EN to also accept opcode
//            0x0B (fast read: address, 8 dummy clocks, then data).
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int MEM_AW      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam int         SYNC_N       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_DATA   = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t            state;
    logic [SYNC_N-1:0] sck_sync;
    logic [SYNC_N-1:0] cs_sync;
    logic [SYNC_N-1:0] mosi_sync;
    logic              sck_prev;
    logic              cs_prev;
    logic [22:0]       shreg;
    logic [4:0]        bit_cnt;
    logic              fast;
    logic              rd_pend;      // mem_rdata is valid this cycle
    logic              first_pend;   // pending read is the first byte of the burst
    logic              skip_fall;    // drop the trailing fall of the last header clock
    logic [7:0]        out_byte;
    logic [7:0]        prefetch;
    logic [2:0]        bit_pos;      // index of the bit currently on spi_miso

    logic              sck_s;
    logic              cs_s;
    logic              mosi_s;
    logic              sck_rise;
    logic              sck_fall;
    logic              cs_fall;
    logic [23:0]       shift_in;
    logic              op_read;
    logic              op_fast;
    logic              unused_bits;

    assign sck_s    = sck_sync[SYNC_N-1];
    assign cs_s     = cs_sync[SYNC_N-1];
    assign mosi_s   = mosi_sync[SYNC_N-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign shift_in = {shreg, mosi_s};
    assign op_read  = (shift_in[7:0] == OP_READ);
`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
    assign op_fast  = (shift_in[7:0] == OP_FAST_READ);
`else
    assign op_fast  = 1'b0;
`endif
    // Address bits above MEM_AW are deliberately discarded.
    assign unused_bits = ^shift_in;

    // Synchronizers. The cs_n chain resets to 0 so that a cs_n held low
    // across reset never looks like a fresh falling edge afterwards.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_N-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_N-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_N-2:0], spi_mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            spi_miso   <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            fast       <= 1'b0;
            rd_pend    <= 1'b0;
            first_pend <= 1'b0;
            skip_fall  <= 1'b0;
            out_byte   <= '0;
            prefetch   <= '0;
            bit_pos    <= '0;
        end else begin
            mem_rd  <= 1'b0;
            cmd_err <= 1'b0;
            rd_pend <= mem_rd;
            if (cs_s) begin
                // Deselected: abandon whatever was in progress.
                state      <= S_IDLE;
                busy       <= 1'b0;
                spi_miso   <= 1'b0;
                shreg      <= '0;
                bit_cnt    <= '0;
                first_pend <= 1'b0;
                skip_fall  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state   <= S_CMD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            shreg   <= shift_in[22:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                fast    <= op_fast;
                                if (op_read || op_fast) begin
                                    state <= S_ADDR;
                                end else begin
                                    state   <= S_IGNORE;
                                    cmd_err <= 1'b1;
                                end
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            shreg   <= shift_in[22:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= '0;
                                mem_addr <= shift_in[MEM_AW-1:0];
                                if (fast) begin
                                    state <= S_DUMMY;
                                end else begin
                                    state      <= S_DATA;
                                    mem_rd     <= 1'b1;
                                    first_pend <= 1'b1;
                                    skip_fall  <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt    <= '0;
                                state      <= S_DATA;
                                mem_rd     <= 1'b1;
                                first_pend <= 1'b1;
                                skip_fall  <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rd_pend) begin
                            if (first_pend) begin
                                out_byte   <= mem_rdata;
                                spi_miso   <= mem_rdata[7];
                                bit_pos    <= 3'd7;
                                first_pend <= 1'b0;
                            end else begin
                                prefetch <= mem_rdata;
                            end
                        end else if (sck_fall) begin
                            if (skip_fall) begin
                                // Bit 7 is already on the pin; this fall ends
                                // the last header clock.
                                skip_fall <= 1'b0;
                            end else if (bit_pos == 3'd0) begin
                                out_byte <= prefetch;
                                spi_miso <= prefetch[7];
                                bit_pos  <= 3'd7;
                            end else begin
                                bit_pos  <= bit_pos - 3'd1;
                                spi_miso <= out_byte[bit_pos - 3'd1];
                                if (bit_pos == 3'd1) begin
                                    // Bit 0 goes out now: fetch the next byte.
                                    mem_addr <= mem_addr + MEM_AW'(1);
                                    mem_rd   <= 1'b1;
                                end
                            end
                        end
                    end
                    S_IGNORE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench for spi_flash_responder. A mode-0 SPI
//            controller model drives transactions; expected MISO bytes are
//            queued as each transaction is issued and popped as bytes return.
//            A bench memory answers mem_rd one clock later; mem_rd addresses
//            and cmd_err cycles are recorded by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

    localparam int MEM_AW = 16;
    localparam int HALF   = 8;   // system clocks per SCK half period

    logic              clock     = 1'b0;
    logic              reset     = 1'b0;
    logic              spi_cs_n  = 1'b1;
    logic              spi_sck   = 1'b0;
    logic              spi_mosi  = 1'b0;
    logic              spi_miso;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              busy;
    logic              cmd_err;

    logic [7:0]        mem [0:(1<<MEM_AW)-1];
    logic [7:0]        exp_q[$];
    logic [MEM_AW-1:0] rd_addr_q[$];
    int                cmd_err_cycles = 0;
    int                checks   = 0;
    int                failures = 0;

    always #5 clock = ~clock;

    spi_flash_responder #(
        .MEM_AW      (MEM_AW),
        .SYNC_STAGES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    // Synchronous memory: data valid one clock after the strobe.
    always @(posedge clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clock) begin
        if (mem_rd)  rd_addr_q.push_back(mem_addr);
        if (cmd_err) cmd_err_cycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bit(input logic tx, output logic rx);
        spi_mosi = tx;
        wait_clks(HALF);
        rx = spi_miso;          // value the controller latches on the rise
        spi_sck = 1'b1;
        wait_clks(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic spi_select();
        spi_cs_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic spi_deselect();
        wait_clks(HALF);
        spi_cs_n = 1'b1;
        wait_clks(4);
        check_value("busy_after_cs_rise", 32'(busy), 32'h0);
        wait_clks(2 * HALF);
    endtask

    task automatic send_header(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] rx;
        spi_xfer(op, rx);
        spi_xfer(addr[23:16], rx);
        spi_xfer(addr[15:8], rx);
        spi_xfer(addr[7:0], rx);
    endtask

    task automatic read_and_score(input string tag, input int n);
        logic [7:0] rx;
        for (int i = 0; i < n; i++) begin
            spi_xfer(8'h00, rx);
            if (exp_q.size() == 0)
                check_value($sformatf("%s_queue_empty_%0d", tag, i), 32'(rx), 32'hFFFF_FFFF);
            else
                check_value($sformatf("%s_byte%0d", tag, i), 32'(rx), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic check_rd_addrs(input string tag, input int n_exp, input logic [MEM_AW-1:0] first);
        logic [MEM_AW-1:0] a;
        check_value({tag, "_rd_count"}, 32'(rd_addr_q.size()), 32'(n_exp));
        a = first;
        for (int i = 0; i < n_exp && i < rd_addr_q.size(); i++) begin
            check_value($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_addr_q[i]), 32'(a));
            a = a + MEM_AW'(1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_miso"},    32'(spi_miso), 32'h0);
        check_value({tag, "_mem_rd"},  32'(mem_rd),   32'h0);
        check_value({tag, "_mem_addr"},32'(mem_addr), 32'h0);
        check_value({tag, "_busy"},    32'(busy),     32'h0);
        check_value({tag, "_cmd_err"}, 32'(cmd_err),  32'h0);
    endtask

    initial begin
        logic b;
        logic [7:0] rx;
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hDE;
        mem[16'h0011] = 8'hAD;
        mem[16'h0012] = 8'hBE;
        mem[16'h0013] = 8'hEF;
        mem[16'h0014] = 8'h11;
        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'hC3;

        // Reset state
        reset = 1'b0;
        wait_clks(4);
        check_reset_outputs("reset");
        reset = 1'b1;
        wait_clks(4);

        // Four-byte read at 0x10. The fifth strobe (0x14) is the prefetch
        // issued as bit 0 of the fourth byte is presented.
        rd_addr_q.delete();
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        spi_select();
        check_value("busy_selected", 32'(busy), 32'h1);
        send_header(8'h03, 24'h000010);
        read_and_score("read10", 4);
        spi_deselect();
        check_rd_addrs("read10", 5, 16'h0010);

        // Wrap from 0xFFFF to 0x0000 (upper address byte ignored)
        rd_addr_q.delete();
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
        spi_select();
        send_header(8'h03, 24'hA5FFFF);
        read_and_score("wrap", 2);
        spi_deselect();
        check_rd_addrs("wrap", 3, 16'hFFFF);

        // Unsupported opcode
        rd_addr_q.delete();
        cmd_err_cycles = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        spi_select();
        spi_xfer(8'h9F, rx);
        read_and_score("badop", 4);
        spi_deselect();
        check_value("badop_cmd_err_cycles", 32'(cmd_err_cycles), 32'h1);
        check_value("badop_rd_count", 32'(rd_addr_q.size()), 32'h0);

        // Abort after 12 address bits, then a clean read
        spi_select();
        spi_xfer(8'h03, rx);
        spi_xfer(8'hFF, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
        spi_deselect();
        rd_addr_q.delete();
        exp_q.push_back(8'hDE);
        spi_select();
        send_header(8'h03, 24'h000010);
        read_and_score("after_abort", 1);
        spi_deselect();
        check_rd_addrs("after_abort", 2, 16'h0010);

        // Reset pulse during the second byte of a read
        exp_q.push_back(8'hDE);
        spi_select();
        send_header(8'h03, 24'h000010);
        read_and_score("prereset", 1);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        rd_addr_q.delete();
        reset = 1'b0;
        wait_clks(1);
        reset = 1'b1;
        check_reset_outputs("midreset");
        exp_q.push_back(8'h00);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, b);
        read_and_score("postreset", 1);
        check_value("postreset_busy", 32'(busy), 32'h0);
        check_value("postreset_rd_count", 32'(rd_addr_q.size()), 32'h0);
        spi_deselect();

        // Fast read opcode
        rd_addr_q.delete();
        cmd_err_cycles = 0;
`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
`else
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
`endif
        spi_select();
        send_header(8'h0B, 24'h000012);
        spi_xfer(8'h00, rx);
        check_value("fast_dummy_miso", 32'(rx), 32'h0);
        read_and_score("fast", 2);
        spi_deselect();
`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
        check_value("fast_cmd_err_cycles", 32'(cmd_err_cycles), 32'h0);
        check_rd_addrs("fast", 3, 16'h0012);
`else
        check_value("fast_cmd_err_cycles", 32'(cmd_err_cycles), 32'h1);
        check_value("fast_rd_count", 32'(rd_addr_q.size()), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
